// File: rtl/map_redraw_engine.sv
// -----------------------------------------------------------------------------
// map_redraw_engine
//
// Purpose: answers the game-state FSM's redraw requests. A drawMap request
// sweeps the whole background image for the current gameState from the
// background ROM mux into the VGA adapter, then raises doneRedraw. A
// startAnimation request redraws only the pillar rectangle. It does this in
// ANIM_STEPS passes. Each pass waits STEP_DELAY cycles first. Each pass then
// raises the pillar by one row. After the last pass, doneAnimation rises.
//
// Ports:
//   clock, reset      system clock; asynchronous active-high reset
//   drawMap           level request for a full redraw of gameState's image
//   startAnimation    level request for the pillar rise (wins over drawMap)
//   gameState         game state code; mapped onto a background image index
//   rom_data          ROM pixel, valid one cycle after rom_sel/rom_addr
//   rom_sel/rom_addr  image index and y*SCREEN_W+x address issued to the ROM
//   x, y, colour      VGA plot coordinate and colour (colour = rom_data)
//   plot              VGA write enable, one cycle per pixel
//   doneRedraw        level: full sweep finished for the latched image
//   doneAnimation     level: pillar animation finished
//
// Handshake: drawMap/startAnimation are levels sampled each cycle. They are
// acted on only in IDLE, in HOLD and in ANIM_DONE. A change while a scan is
// running is ignored until that scan ends. doneRedraw/doneAnimation are
// levels. The requester sees them and then drops its request.
// The FSM state is held in the enum register 'state'.
// -----------------------------------------------------------------------------
module map_redraw_engine #(
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240,
  parameter int COLOUR_W   = 9,
  parameter int PILLAR_X0  = 156,
  parameter int PILLAR_X1  = 175,
  parameter int PILLAR_Y0  = 56,
  parameter int PILLAR_Y1  = 120,
  parameter int ANIM_STEPS = 16,
  parameter int STEP_DELAY = 833333
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                drawMap,
  input  logic                startAnimation,
  input  logic [3:0]          gameState,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [2:0]          rom_sel,
  output logic [16:0]         rom_addr,
  output logic [8:0]          x,
  output logic [7:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                doneRedraw,
  output logic                doneAnimation
);

  localparam int STEP_W  = $clog2(ANIM_STEPS + 1);
  localparam int DELAY_W = $clog2(STEP_DELAY + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SWEEP     = 3'd1,
    HOLD      = 3'd2,
    ANIM_WAIT = 3'd3,
    ANIM_DRAW = 3'd4,
    ANIM_DONE = 3'd5
  } state_t;

  state_t               state;
  logic [8:0]           scanX;
  logic [7:0]           scanY;
  logic                 lastIssued;   // final address of this scan already issued
  logic [2:0]           latchedImage;
  logic [STEP_W-1:0]    step;
  logic [DELAY_W-1:0]   delayCnt;

  // Scan-window bounds for the running scan.
  logic [8:0] firstX;
  logic [8:0] lastX;
  logic [7:0] lastY;

  // Address generation.
  logic       issue;
  logic [2:0] issueSel;
  logic [8:0] addrX;
  logic [7:0] addrY;
  logic [8:0] off;
  logic [8:0] sy;

  function automatic logic [2:0] imageOf(input logic [3:0] gs);
    case (gs)
      4'd0, 4'd1:        return 3'd0;
      4'd2, 4'd3:        return 3'd1;
      4'd4, 4'd5:        return 3'd2;
      4'd6, 4'd7:        return 3'd3;
      4'd8, 4'd9, 4'd10: return 3'd4;
      4'd11:             return 3'd5;
      default:           return 3'd0;
    endcase
  endfunction

  always_comb begin
    firstX = '0;
    lastX  = 9'(SCREEN_W - 1);
    lastY  = 8'(SCREEN_H - 1);
    if (state == ANIM_DRAW) begin
      firstX = 9'(PILLAR_X0);
      lastX  = 9'(PILLAR_X1);
      lastY  = 8'(PILLAR_Y1);
    end
  end

  // During the pillar rise, pass 'step' draws the pillar image shifted down by
  // off rows. Rows that move past the pillar bottom show the plain image
  // underneath (image 3) at their own row.
  always_comb begin
    issue    = 1'b0;
    issueSel = '0;
    addrX    = scanX;
    addrY    = scanY;
    off      = 9'(ANIM_STEPS) - 9'(step);
    sy       = 9'(scanY) + off;
    if (state == SWEEP && !lastIssued) begin
      issue    = 1'b1;
      issueSel = latchedImage;
    end else if (state == ANIM_DRAW && !lastIssued) begin
      issue = 1'b1;
      if (sy <= 9'(PILLAR_Y1)) begin
        issueSel = 3'd4;
        addrY    = sy[7:0];
      end else begin
        issueSel = 3'd3;
      end
    end
  end

  assign rom_sel  = issue ? issueSel : 3'd0;
  assign rom_addr = issue ? (17'(addrY) * 17'(SCREEN_W) + 17'(addrX)) : 17'd0;
  // rom_data answers last cycle's address, which is this cycle's plot pixel.
  assign colour   = plot ? rom_data : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      scanX         <= '0;
      scanY         <= '0;
      lastIssued    <= 1'b0;
      latchedImage  <= '0;
      step          <= '0;
      delayCnt      <= '0;
      x             <= '0;
      y             <= '0;
      plot          <= 1'b0;
      doneRedraw    <= 1'b0;
      doneAnimation <= 1'b0;
    end else begin
      // Plot outputs trail the issued address by one cycle.
      plot <= issue;
      if (issue) begin
        x <= scanX;
        y <= scanY;
        // x fastest, then y. Counters hold at the final pixel.
        if (scanX == lastX) begin
          if (scanY == lastY) begin
            lastIssued <= 1'b1;
          end else begin
            scanX <= firstX;
            scanY <= scanY + 8'd1;
          end
        end else begin
          scanX <= scanX + 9'd1;
        end
      end

      case (state)
        IDLE: begin
          if (startAnimation) begin
            state         <= ANIM_WAIT;
            step          <= STEP_W'(1);
            delayCnt      <= '0;
            doneAnimation <= 1'b0;
          end else if (drawMap && !doneRedraw) begin
            state        <= SWEEP;
            latchedImage <= imageOf(gameState);
            scanX        <= '0;
            scanY        <= '0;
            lastIssued   <= 1'b0;
          end
        end

        SWEEP: begin
          // The cycle after the last address is issued, that pixel is plotted.
          if (lastIssued) begin
            doneRedraw <= 1'b1;
            state      <= HOLD;
          end
        end

        HOLD: begin
          if (!drawMap) begin
            doneRedraw <= 1'b0;
            state      <= IDLE;
          end else if (imageOf(gameState) != latchedImage) begin
            doneRedraw   <= 1'b0;
            state        <= SWEEP;
            latchedImage <= imageOf(gameState);
            scanX        <= '0;
            scanY        <= '0;
            lastIssued   <= 1'b0;
          end else if (startAnimation) begin
            doneRedraw    <= 1'b0;
            state         <= ANIM_WAIT;
            step          <= STEP_W'(1);
            delayCnt      <= '0;
            doneAnimation <= 1'b0;
          end
        end

        ANIM_WAIT: begin
          if (delayCnt == DELAY_W'(STEP_DELAY - 1)) begin
            state      <= ANIM_DRAW;
            scanX      <= 9'(PILLAR_X0);
            scanY      <= 8'(PILLAR_Y0);
            lastIssued <= 1'b0;
          end else begin
            delayCnt <= delayCnt + DELAY_W'(1);
          end
        end

        ANIM_DRAW: begin
          if (lastIssued) begin
            if (step == STEP_W'(ANIM_STEPS)) begin
              doneAnimation <= 1'b1;
              state         <= ANIM_DONE;
            end else begin
              step     <= step + STEP_W'(1);
              delayCnt <= '0;
              state    <= ANIM_WAIT;
            end
          end
        end

        ANIM_DONE: begin
          if (!startAnimation) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_map_redraw_engine.sv
// -----------------------------------------------------------------------------
// Bench for map_redraw_engine. It uses a reduced screen and pillar so that
// every scenario fits a short run. A reference model builds the expected plot
// stream (x, y, colour) from the redraw rules. A negedge monitor pops that
// stream whenever plot is high.
// -----------------------------------------------------------------------------
module tb_map_redraw_engine;

  localparam int W  = 40;
  localparam int H  = 30;
  localparam int X0 = 10;
  localparam int X1 = 14;
  localparam int Y0 = 5;
  localparam int Y1 = 20;
  localparam int NS = 3;
  localparam int SD = 4;
  localparam int CW = 9;

  logic          clock;
  logic          reset;
  logic          drawMap;
  logic          startAnimation;
  logic [3:0]    gameState;
  logic [CW-1:0] romData;
  logic [2:0]    romSel;
  logic [16:0]   romAddr;
  logic [8:0]    x;
  logic [7:0]    y;
  logic [CW-1:0] colour;
  logic          plot;
  logic          doneRedraw;
  logic          doneAnimation;

  map_redraw_engine #(
    .SCREEN_W(W), .SCREEN_H(H), .COLOUR_W(CW),
    .PILLAR_X0(X0), .PILLAR_X1(X1), .PILLAR_Y0(Y0), .PILLAR_Y1(Y1),
    .ANIM_STEPS(NS), .STEP_DELAY(SD)
  ) dut (
    .clock(clock), .reset(reset), .drawMap(drawMap),
    .startAnimation(startAnimation), .gameState(gameState),
    .rom_data(romData), .rom_sel(romSel), .rom_addr(romAddr),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .doneRedraw(doneRedraw), .doneAnimation(doneAnimation)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ROM model (one-cycle latency) ----------------
  function automatic logic [CW-1:0] romPixel(input int sel, input int addr);
    logic [31:0] h;
    h = 32'(addr) * 32'd40503 + 32'(sel) * 32'd977 + 32'd13;
    return h[20:12] ^ h[8:0];
  endfunction

  always @(posedge clock) romData <= romPixel(int'(romSel), int'(romAddr));

  // ---------------- reference model ----------------
  function automatic int refImage(input int gs);
    if (gs <= 1)  return 0;
    if (gs <= 3)  return 1;
    if (gs <= 5)  return 2;
    if (gs <= 7)  return 3;
    if (gs <= 10) return 4;
    if (gs == 11) return 5;
    return 0;
  endfunction

  logic [25:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int plotCount = 0;

  function automatic logic [25:0] pix(input int px, input int py, input logic [CW-1:0] c);
    return {9'(px), 8'(py), c};
  endfunction

  task automatic pushSweep(input int img);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        exp_q.push_back(pix(xx, yy, romPixel(img, yy * W + xx)));
  endtask

  // Pass s shows the pillar image shifted down by NS-s rows. Rows shifted out
  // of the pillar show the image underneath.
  task automatic pushAnim();
    for (int s = 1; s <= NS; s++)
      for (int yy = Y0; yy <= Y1; yy++)
        for (int xx = X0; xx <= X1; xx++) begin
          int sy;
          sy = yy + NS - s;
          if (sy <= Y1) exp_q.push_back(pix(xx, yy, romPixel(4, sy * W + xx)));
          else          exp_q.push_back(pix(xx, yy, romPixel(3, yy * W + xx)));
        end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  always @(negedge clock) begin
    if (!reset && plot) begin
      plotCount++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_plot: x=%0d y=%0d colour=0x%0h, no plot expected", x, y, colour);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        check("plot_pixel {x,y,colour}", {6'd0, x, y, colour}, {6'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic waitDoneRedraw(output int n);
    n = 0;
    while (!doneRedraw && n < W * H + 50) begin
      tick(1);
      n++;
    end
    if (!doneRedraw) begin
      checks++;
      $display("FAIL doneRedraw_timeout: still 0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic waitDoneAnim();
    int n;
    n = 0;
    while (!doneAnimation && n < 1000) begin
      tick(1);
      n++;
    end
    if (!doneAnimation) begin
      checks++;
      $display("FAIL doneAnimation_timeout: still 0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic runSweep(input int gs, output int n);
    gameState = 4'(gs);
    pushSweep(refImage(gs));
    drawMap = 1'b1;
    waitDoneRedraw(n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int gs;
    int lowCycles;
    int base;
    reset = 1'b1;
    drawMap = 1'b0;
    startAnimation = 1'b0;
    gameState = 4'd0;
    tick(3);
    check("reset_plot", plot, 0);
    check("reset_doneRedraw", doneRedraw, 0);
    check("reset_doneAnimation", doneAnimation, 0);
    check("reset_rom_sel", romSel, 0);
    check("reset_rom_addr", romAddr, 0);
    check("reset_x", x, 0);
    check("reset_y", y, 0);
    check("reset_colour", colour, 0);
    reset = 1'b0;
    tick(2);

    // Full sweep of image 0: timing of the first address and of doneRedraw.
    gameState = 4'd0;
    pushSweep(0);
    drawMap = 1'b1;
    tick(5);
    check("sweep0_rom_sel", romSel, 0);
    check("sweep0_rom_addr_cycle5", romAddr, 4);
    waitDoneRedraw(n);
    check("sweep0_done_latency", n + 5, W * H + 2);
    check("sweep0_queue_empty", exp_q.size(), 0);
    tick(10);
    check("hold_doneRedraw", doneRedraw, 1);
    drawMap = 1'b0;
    tick(1);
    check("hold_exit_doneRedraw", doneRedraw, 0);
    tick(2);

    // Randomised game states.
    repeat (4) begin
      gs = $urandom_range(0, 15);
      gameState = 4'(gs);
      pushSweep(refImage(gs));
      drawMap = 1'b1;
      tick(7);
      check("rand_sweep_rom_sel", romSel, refImage(gs));
      waitDoneRedraw(n);
      check("rand_sweep_queue_empty", exp_q.size(), 0);
      drawMap = 1'b0;
      tick(2);
    end

    // HOLD: a gameState change with the same image is ignored; a new image resweeps.
    runSweep(2, n);
    gameState = 4'd3;
    tick(10);
    check("hold_same_image_doneRedraw", doneRedraw, 1);
    pushSweep(2);
    gameState = 4'd4;
    tick(2);
    check("hold_new_image_doneRedraw_drop", doneRedraw, 0);
    tick(3);
    check("hold_new_image_rom_sel", romSel, 2);
    waitDoneRedraw(n);
    check("resweep_queue_empty", exp_q.size(), 0);
    drawMap = 1'b0;
    tick(2);

    // drawMap falls mid-sweep: the sweep completes, then HOLD exits at once.
    runSweep(0, n);
    drawMap = 1'b0;
    tick(2);
    gs = $urandom_range(6, 10);
    gameState = 4'(gs);
    pushSweep(refImage(gs));
    drawMap = 1'b1;
    tick(100);
    drawMap = 1'b0;
    waitDoneRedraw(n);
    check("drop_mid_sweep_queue_empty", exp_q.size(), 0);
    tick(1);
    check("drop_mid_sweep_hold_exit", doneRedraw, 0);
    tick(3);

    // startAnimation raised mid-sweep: the sweep completes, then HOLD starts the animation.
    gameState = 4'd5;
    pushSweep(2);
    pushAnim();
    drawMap = 1'b1;
    tick(50);
    startAnimation = 1'b1;
    waitDoneRedraw(n);
    waitDoneAnim();
    check("sweep_then_anim_queue_empty", exp_q.size(), 0);
    check("sweep_then_anim_doneRedraw", doneRedraw, 0);
    drawMap = 1'b0;
    startAnimation = 1'b0;
    tick(3);
    check("anim_done_held_in_idle", doneAnimation, 1);

    // Reset in the middle of a sweep.
    gs = $urandom_range(0, 11);
    gameState = 4'(gs);
    pushSweep(refImage(gs));
    drawMap = 1'b1;
    base = plotCount;
    n = 0;
    while (plotCount - base < 500 && n < W * H) begin
      tick(1);
      n++;
    end
    check("mid_sweep_plot_count", plotCount - base, 500);
    reset = 1'b1;
    #1;
    check("mid_reset_plot", plot, 0);
    check("mid_reset_doneRedraw", doneRedraw, 0);
    check("mid_reset_doneAnimation", doneAnimation, 0);
    exp_q.delete();
    drawMap = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(30);
    check("after_reset_no_plots", exp_q.size(), 0);

    // Animation from IDLE.
    pushAnim();
    startAnimation = 1'b1;
    waitDoneAnim();
    check("anim_queue_empty", exp_q.size(), 0);
    tick(10);
    check("anim_done_holds", doneAnimation, 1);
    startAnimation = 1'b0;
    tick(3);
    check("anim_done_after_release", doneAnimation, 1);

    // drawMap and startAnimation together: only the animation runs.
    gameState = 4'd0;
    pushAnim();
    drawMap = 1'b1;
    startAnimation = 1'b1;
    tick(2);
    check("both_doneAnimation_cleared", doneAnimation, 0);
    waitDoneAnim();
    check("both_queue_empty", exp_q.size(), 0);
    check("both_no_redraw", doneRedraw, 0);
    drawMap = 1'b0;
    startAnimation = 1'b0;
    tick(3);

    // gameState 11 held: one sweep, then doneRedraw stays high.
    gameState = 4'd11;
    pushSweep(5);
    drawMap = 1'b1;
    tick(5);
    check("gs11_rom_sel", romSel, 5);
    waitDoneRedraw(n);
    lowCycles = 0;
    for (int i = 0; i < 2 * W * H; i++) begin
      tick(1);
      if (!doneRedraw) lowCycles++;
    end
    check("gs11_doneRedraw_low_cycles", lowCycles, 0);
    check("gs11_queue_empty", exp_q.size(), 0);
    drawMap = 1'b0;
    tick(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
